// File: rtl/perf_pkg.sv
// Shared definitions for the performance counter bank: channel map, defaults and helpers.
package perf_pkg;

  localparam int unsigned PERF_NUM_EVENTS = 8;
  localparam int unsigned SNAP_SEQ_W      = 8;

  typedef enum logic [4:0] {
    EV_INSTR       = 5'd0,
    EV_BRANCH      = 5'd1,
    EV_JUMP        = 5'd2,
    EV_MISPRED     = 5'd3,
    EV_ICACHE_MISS = 5'd4,
    EV_DCACHE_MISS = 5'd5,
    EV_STALL       = 5'd6,
    EV_FLUSH       = 5'd7
  } perf_event_e;

  // Snapshot bookkeeping carried alongside the captured counter set.
  typedef struct packed {
    logic                  valid;
    logic [SNAP_SEQ_W-1:0] seq;
  } perf_snap_hdr_t;

  // Read-select width; a single-channel bank still gets a 1-bit select.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perf_counter_bank_if.sv
// Control, event and read-back signals of the performance counter bank.
interface perf_counter_bank_if #(
  parameter int unsigned NUM_EVENTS = perf_pkg::PERF_NUM_EVENTS,
  parameter int unsigned CNT_WIDTH  = 32
);

  localparam int unsigned SEL_W = perf_pkg::sel_width(NUM_EVENTS);

  logic                  load;
  logic [NUM_EVENTS-1:0] events;
  logic                  ctl_clear;
  logic                  ctl_freeze;
  logic                  snap_req;
  logic [SEL_W-1:0]      rd_sel;
  logic [CNT_WIDTH-1:0]  rd_live;
  logic [CNT_WIDTH-1:0]  rd_snap;
  logic [CNT_WIDTH-1:0]  cycle_count;
  logic [CNT_WIDTH-1:0]  snap_cycles;
  logic                  snap_valid;
  logic [7:0]            snap_seq;
  logic [NUM_EVENTS-1:0] ovf;

  modport master (
    output load, events, ctl_clear, ctl_freeze, snap_req, rd_sel,
    input  rd_live, rd_snap, cycle_count, snap_cycles, snap_valid, snap_seq, ovf
  );

  modport slave (
    input  load, events, ctl_clear, ctl_freeze, snap_req, rd_sel,
    output rd_live, rd_snap, cycle_count, snap_cycles, snap_valid, snap_seq, ovf
  );

endinterface

// File: rtl/perf_counter_cell.sv
// One event counter with saturate/wrap overflow handling and a sticky overflow flag.
module perf_counter_cell #(
  parameter int unsigned CNT_WIDTH = 32,
  parameter bit          SATURATE  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc_i,
  input  logic                 clr_i,
  input  logic                 ovf_clr_i,
  input  logic                 hold_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 ovf_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  // Clear beats increment; the overflow flag has its own clear so a
  // window restart can zero the count while keeping the sticky flag.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !hold_i) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
        cnt_d = {CNT_WIDTH{SATURATE}};
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
    if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of per-event counters plus a cycle counter, with snapshot capture,
// optional auto-snapshot window (read-and-clear) and channel read muxes.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int unsigned NUM_EVENTS = PERF_NUM_EVENTS,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter bit          SATURATE   = 1'b1,
  parameter int unsigned WINDOW     = 0
) (
  input logic                clk,
  input logic                rst,
  perf_counter_bank_if.slave bus
);

  localparam int unsigned SEL_W = sel_width(NUM_EVENTS);
  localparam int unsigned WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = (WINDOW > 0) ? WIN_W'(WINDOW - 1) : '0;

  logic [CNT_WIDTH-1:0]  live_c [NUM_EVENTS];
  logic [NUM_EVENTS-1:0] ovf_c;
  logic [CNT_WIDTH-1:0]  cyc_c;
  logic                  cyc_ovf_unused;

  logic expire_c;
  logic trig_c;
  logic clr_c;

  logic [WIN_W-1:0]     win_q, win_d;
  logic [CNT_WIDTH-1:0] snap_q [NUM_EVENTS];
  logic [CNT_WIDTH-1:0] snap_d [NUM_EVENTS];
  logic [CNT_WIDTH-1:0] snap_cyc_q, snap_cyc_d;
  perf_snap_hdr_t       hdr_q, hdr_d;

  logic [CNT_WIDTH-1:0] rd_live_c;
  logic [CNT_WIDTH-1:0] rd_snap_c;

  // Window expiry is a read-and-clear: snapshot, then restart live state.
  assign expire_c = (WINDOW > 0) && !bus.ctl_freeze && (win_q == WIN_LAST);
  assign trig_c   = bus.snap_req | expire_c;
  assign clr_c    = bus.ctl_clear | expire_c;

  for (genvar i = 0; i < NUM_EVENTS; i++) begin : g_evt
    perf_counter_cell #(
      .CNT_WIDTH (CNT_WIDTH),
      .SATURATE  (SATURATE)
    ) u_cell (
      .clk       (clk),
      .rst       (rst),
      .inc_i     (bus.load & bus.events[i]),
      .clr_i     (clr_c),
      .ovf_clr_i (bus.ctl_clear),
      .hold_i    (bus.ctl_freeze),
      .cnt_o     (live_c[i]),
      .ovf_o     (ovf_c[i])
    );
  end

  perf_counter_cell #(
    .CNT_WIDTH (CNT_WIDTH),
    .SATURATE  (SATURATE)
  ) u_cycle (
    .clk       (clk),
    .rst       (rst),
    .inc_i     (1'b1),
    .clr_i     (clr_c),
    .ovf_clr_i (bus.ctl_clear),
    .hold_i    (bus.ctl_freeze),
    .cnt_o     (cyc_c),
    .ovf_o     (cyc_ovf_unused)
  );

  always_comb begin
    win_d = win_q;
    if (bus.ctl_clear || expire_c || (WINDOW == 0)) begin
      win_d = '0;
    end else if (!bus.ctl_freeze) begin
      win_d = win_q + WIN_W'(1);
    end
  end

  // Capture uses the pre-edge live values, so a same-edge clear still reads them.
  always_comb begin
    snap_d     = snap_q;
    snap_cyc_d = snap_cyc_q;
    hdr_d      = hdr_q;
    if (trig_c) begin
      for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
        snap_d[i] = live_c[i];
      end
      snap_cyc_d  = cyc_c;
      hdr_d.seq   = hdr_q.seq + SNAP_SEQ_W'(1);
      hdr_d.valid = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q      <= '0;
      snap_cyc_q <= '0;
      hdr_q      <= '0;
      for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      win_q      <= win_d;
      snap_cyc_q <= snap_cyc_d;
      hdr_q      <= hdr_d;
      for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
        snap_q[i] <= snap_d[i];
      end
    end
  end

  // Out-of-range selects match no channel and read zero.
  always_comb begin
    rd_live_c = '0;
    rd_snap_c = '0;
    for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
      if (bus.rd_sel == SEL_W'(i)) begin
        rd_live_c = live_c[i];
        rd_snap_c = snap_q[i];
      end
    end
  end

  assign bus.rd_live     = rd_live_c;
  assign bus.rd_snap     = rd_snap_c;
  assign bus.cycle_count = cyc_c;
  assign bus.snap_cycles = snap_cyc_q;
  assign bus.snap_valid  = hdr_q.valid;
  assign bus.snap_seq    = hdr_q.seq;
  assign bus.ovf         = ovf_c;

endmodule
